exec_alu_mc: RTL and testbench
==============================

Name: exec_alu_mc

Overview:
- Parametrised successor to the single-cycle execute ALU for the NoobsCpu core.
- Executes ALU operations on DATA_W-bit operands and accepts work through a valid/ready handshake.
- Adds carry-chained ADC/SBC, shifts, compare and an iterative multi-cycle multiply.
- Sits between decode/regfile read and register writeback, and owns the status register (SR).

Parameters:
- DATA_W, 8: operand/result width (>=4).
- SEL_W, 2: destination register select width.
- MUL_EN, 1: 1 = MUL implemented; 0 = MUL opcode traps as illegal.

Ports:
- clk  in  1  clock.
- reset_  in  1  reset (asynchronous, active-high).
- in_vld  in  1  operation valid.
- in_rdy  out  1  unit can accept (state IDLE).
- op  in  4  opcode.
- src0  in  DATA_W  operand 0.
- src1  in  DATA_W  operand 1 (register or immediate, muxed upstream).
- dst_sel  in  SEL_W  writeback register select.
- res_vld  out  1  one-cycle completion pulse.
- wr_en  out  1  register write strobe (subset of res_vld).
- wr_sel  out  SEL_W  registered dst_sel of the completing op.
- wr_data  out  DATA_W  result, low half.
- wr_data_hi  out  DATA_W  MUL high half; 0 for other ops.
- sr_wr  in  1  software SR write.
- sr_wr_data  in  8  SR write value.
- trap_clr  in  1  clears sticky TRP.
- sr  out  8  status register.
- busy  out  1  multiply in progress.

Behaviour:
- Reset (async assert): state=IDLE, sr=0, res_vld=0, wr_en=0, wr_sel=0, wr_data=0, wr_data_hi=0, busy=0, multiply counter=0. An in-flight MUL is discarded; no res_vld after reset release. in_rdy=1 once reset deasserts.
- SR map: [0] OVF/carry, [1] ST-OVF (reserved, reads 0 here), [2] NZ, [3] Z, [4] TRP (sticky), [7:5] 0.
- Accept on a clk edge with in_vld&in_rdy. in_vld while in_rdy=0 is ignored; no queuing.
- Opcodes:
  - 0 NOP: no res_vld, SR unchanged.
  - 1 ADD: {C,r}=src0+src1.
  - 2 SUB: {B,r}=src0-src1 in DATA_W+1 bits; OVF = borrow.
  - 3 OR, 4 AND, 5 XOR: OVF cleared.
  - 6 ADC: src0+src1+SR[0].
  - 7 SBC: src0-src1-SR[0].
  - 8 SHL: r=src0<<1, OVF=src0[MSB].
  - 9 SHR: logical, r=src0>>1, OVF=src0[0].
  - A MUL: unsigned 2*DATA_W product.
  - B CMP: SUB flags only, wr_en=0.
  - C-F: illegal.
- Z/NZ: Z=(r==0), NZ=~Z. For MUL, computed on the full product; MUL OVF=(hi!=0).
- Single-cycle ops (1-9, B): results and SR registered at the accept edge. res_vld is high the following cycle. State stays IDLE, so throughput is 1 op/cycle back-to-back.
- FSM:
  - IDLE -> MUL on accepting MUL. Counter loads DATA_W; one shift-add iteration per cycle; busy=1.
  - MUL -> DONE after DATA_W iterations. DONE: res_vld=wr_en=1, wr_data/wr_data_hi valid, SR updated.
  - DONE -> IDLE.
  - in_rdy=0 in MUL and DONE. Accept-to-res_vld latency is DATA_W+1 cycles; next accept is possible in the cycle after DONE.
- Illegal op: one-cycle accept; no res_vld/wr_en; SR[4] set; SR[3:0] unchanged. TRP stays set across later ops until trap_clr or sr_wr.
- Priority on the same edge:
  - sr_wr beats an op completion: SR=sr_wr_data&8'h1F, but wr_data/wr_en still issue.
  - trap_clr beats a simultaneous illegal op (TRP ends 0).
- wr_data/wr_data_hi/wr_sel hold their last values when res_vld=0. wr_en never asserts without res_vld.
- ADC/SBC use SR[0] as registered before the accept edge, so back-to-back ADC chains carry correctly.

Test Plan:
- DATA_W=8. ADD F0+20 -> next cycle res_vld=wr_en=1, wr_data=10, sr=05.
- SUB 03-05 -> wr_data=FE, sr=05. Then immediately SBC 10-01 -> wr_data=0E, sr=04. Then SUB 05-05 -> wr_data=00, sr=08.
- MUL 12*34 accepted at edge N -> in_rdy=0 and busy=1 for cycles N+1..N+8. At N+9: res_vld=1, wr_data=A8, wr_data_hi=03, sr=05. At N+10: in_rdy=1. Repeat with MUL_EN=0 -> TRP set, no res_vld.
- Op F with sr=04 -> no wr_en, sr=14. Then ADD 01+01 -> sr=14. Then trap_clr -> sr=04. Also trap_clr with op F on the same edge -> TRP=0.
- MUL accepted, reset_ asserted asynchronously 4 cycles later -> all outputs 0 immediately. After release: in_rdy=1 and no spurious res_vld for 20 cycles.
- CMP 40,40 -> res_vld=1, wr_en=0, sr=08. sr_wr=1 with data FF on the same edge as ADD completion -> sr=1F, wr_en=1 still.

Source files
------------

// File: rtl/exec_alu_mc.sv
// Execute ALU for the NoobsCpu core: single-cycle arithmetic/logic/shift ops plus an
// iterative shift-add multiply, valid/ready input, registered writeback and status register.
module exec_alu_mc #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] src0,
    input  logic [DATA_W-1:0] src1,
    input  logic [SEL_W-1:0]  dst_sel,
    output logic              res_vld,
    output logic              wr_en,
    output logic [SEL_W-1:0]  wr_sel,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] wr_data_hi,
    input  logic              sr_wr,
    input  logic [7:0]        sr_wr_data,
    input  logic              trap_clr,
    output logic [7:0]        sr,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_OR  = 4'h3,
                           OP_AND = 4'h4, OP_XOR = 4'h5, OP_ADC = 4'h6, OP_SBC = 4'h7,
                           OP_SHL = 4'h8, OP_SHR = 4'h9, OP_MUL = 4'hA, OP_CMP = 4'hB;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*DATA_W-1:0]     acc_q, acc_d;
    logic [2*DATA_W-1:0]     mcand_q, mcand_d;
    logic [DATA_W-1:0]       mplier_q, mplier_d;
    logic [SEL_W-1:0]        mul_sel_q, mul_sel_d;
    logic [7:0]              sr_q, sr_d;
    logic                    res_vld_q, res_vld_d;
    logic                    wr_en_q, wr_en_d;
    logic [SEL_W-1:0]        wr_sel_q, wr_sel_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;
    logic [DATA_W-1:0]       wr_data_hi_q, wr_data_hi_d;

    logic [DATA_W:0]         a_ext, b_ext, cin, alu_r;
    logic                    op_legal, op_single, accept, mul_z;

    // SR layout: {3'b0, TRP, Z, NZ, ST-OVF(0), OVF}
    function automatic logic [7:0] mk_sr(input logic trp, input logic z, input logic ovf);
        return {3'b000, trp, z, ~z, 1'b0, ovf};
    endfunction

    assign in_rdy = (state_q == S_IDLE) && !reset_;
    assign accept = in_vld && in_rdy;

    // Bit DATA_W of alu_r is the OVF flag for every single-cycle op.
    always_comb begin
        a_ext     = {1'b0, src0};
        b_ext     = {1'b0, src1};
        cin       = '0;
        alu_r     = '0;
        op_legal  = 1'b1;
        op_single = 1'b1;
        if (op == OP_ADC || op == OP_SBC)
            cin = {{DATA_W{1'b0}}, sr_q[0]};
        case (op)
            OP_NOP:                 op_single = 1'b0;
            OP_ADD, OP_ADC:         alu_r = a_ext + b_ext + cin;
            OP_SUB, OP_SBC, OP_CMP: alu_r = a_ext - b_ext - cin;
            OP_OR:                  alu_r = a_ext | b_ext;
            OP_AND:                 alu_r = a_ext & b_ext;
            OP_XOR:                 alu_r = a_ext ^ b_ext;
            OP_SHL:                 alu_r = {src0[DATA_W-1], src0[DATA_W-2:0], 1'b0};
            OP_SHR:                 alu_r = {src0[0], 1'b0, src0[DATA_W-1:1]};
            OP_MUL: begin
                op_single = 1'b0;
                op_legal  = (MUL_EN != 0);
            end
            default: begin
                op_single = 1'b0;
                op_legal  = 1'b0;
            end
        endcase
    end

    assign mul_z = (acc_q == '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        mul_sel_d    = mul_sel_q;
        sr_d         = sr_q;
        res_vld_d    = 1'b0;
        wr_en_d      = 1'b0;
        wr_sel_d     = wr_sel_q;
        wr_data_d    = wr_data_q;
        wr_data_hi_d = wr_data_hi_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!op_legal) begin
                        sr_d[4] = 1'b1;
                    end else if (op_single) begin
                        res_vld_d    = 1'b1;
                        wr_en_d      = (op != OP_CMP);
                        wr_sel_d     = dst_sel;
                        wr_data_d    = alu_r[DATA_W-1:0];
                        wr_data_hi_d = '0;
                        sr_d = mk_sr(sr_q[4], alu_r[DATA_W-1:0] == '0, alu_r[DATA_W]);
                    end else if (op == OP_MUL) begin
                        state_d   = S_MUL;
                        cnt_d     = CNT_W'(DATA_W);
                        acc_d     = '0;
                        mcand_d   = {{DATA_W{1'b0}}, src0};
                        mplier_d  = src1;
                        mul_sel_d = dst_sel;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q != '0) begin
                    if (mplier_q[0])
                        acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - 1'b1;
                end else begin
                    // All iterations done: publish the product from the DONE state.
                    state_d      = S_DONE;
                    res_vld_d    = 1'b1;
                    wr_en_d      = 1'b1;
                    wr_sel_d     = mul_sel_q;
                    wr_data_d    = acc_q[DATA_W-1:0];
                    wr_data_hi_d = acc_q[2*DATA_W-1:DATA_W];
                    sr_d = mk_sr(sr_q[4], mul_z, |acc_q[2*DATA_W-1:DATA_W]);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (trap_clr)
            sr_d[4] = 1'b0;
        if (sr_wr)
            sr_d = sr_wr_data & 8'h1F;
    end

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            mul_sel_q    <= '0;
            sr_q         <= '0;
            res_vld_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_sel_q     <= '0;
            wr_data_q    <= '0;
            wr_data_hi_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            mul_sel_q    <= mul_sel_d;
            sr_q         <= sr_d;
            res_vld_q    <= res_vld_d;
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_data_q    <= wr_data_d;
            wr_data_hi_q <= wr_data_hi_d;
        end
    end

    assign res_vld    = res_vld_q;
    assign wr_en      = wr_en_q;
    assign wr_sel     = wr_sel_q;
    assign wr_data    = wr_data_q;
    assign wr_data_hi = wr_data_hi_q;
    assign sr         = sr_q;
    assign busy       = (state_q == S_MUL);
endmodule

// File: tb/tb_exec_alu_mc.sv
// Directed bench for exec_alu_mc: one instance with the multiplier, one with MUL trapping.
module tb_exec_alu_mc;
    logic       clk, reset_, in_vld, sr_wr, trap_clr;
    logic [3:0] op;
    logic [7:0] src0, src1, sr_wr_data;
    logic [1:0] dst_sel;

    logic       in_rdy1, res_vld1, wr_en1, busy1;
    logic [1:0] wr_sel1;
    logic [7:0] wr_data1, wr_data_hi1, sr1;
    logic       in_rdy0, res_vld0, wr_en0, busy0;
    logic [1:0] wr_sel0;
    logic [7:0] wr_data0, wr_data_hi0, sr0;

    int tests = 0;
    int fails = 0;

    exec_alu_mc #(.DATA_W(8), .SEL_W(2), .MUL_EN(1)) u_mul (
        .clk(clk), .reset_(reset_), .in_vld(in_vld), .in_rdy(in_rdy1), .op(op),
        .src0(src0), .src1(src1), .dst_sel(dst_sel), .res_vld(res_vld1), .wr_en(wr_en1),
        .wr_sel(wr_sel1), .wr_data(wr_data1), .wr_data_hi(wr_data_hi1), .sr_wr(sr_wr),
        .sr_wr_data(sr_wr_data), .trap_clr(trap_clr), .sr(sr1), .busy(busy1));

    exec_alu_mc #(.DATA_W(8), .SEL_W(2), .MUL_EN(0)) u_nomul (
        .clk(clk), .reset_(reset_), .in_vld(in_vld), .in_rdy(in_rdy0), .op(op),
        .src0(src0), .src1(src1), .dst_sel(dst_sel), .res_vld(res_vld0), .wr_en(wr_en0),
        .wr_sel(wr_sel0), .wr_data(wr_data0), .wr_data_hi(wr_data_hi0), .sr_wr(sr_wr),
        .sr_wr_data(sr_wr_data), .trap_clr(trap_clr), .sr(sr0), .busy(busy0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one op for exactly one edge, then drop in_vld.
    task automatic run(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] sel);
        in_vld = 1'b1; op = o; src0 = a; src1 = b; dst_sel = sel;
        cyc();
        in_vld = 1'b0; op = 4'h0;
    endtask

    initial begin
        reset_ = 1'b1; in_vld = 1'b0; op = 4'h0; src0 = 8'h00; src1 = 8'h00;
        dst_sel = 2'd0; sr_wr = 1'b0; sr_wr_data = 8'h00; trap_clr = 1'b0;
        #1;
        chk("rst_sr", sr1, 8'h00);
        chk("rst_res_vld", res_vld1, 1'b0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_wr_data", wr_data1, 8'h00);
        cyc(); cyc();
        reset_ = 1'b0;
        #1;
        chk("rst_in_rdy", in_rdy1, 1'b1);

        run(4'h1, 8'hF0, 8'h20, 2'd1);
        chk("add_res_vld", res_vld1, 1'b1);
        chk("add_wr_en", wr_en1, 1'b1);
        chk("add_data", wr_data1, 8'h10);
        chk("add_sel", wr_sel1, 2'd1);
        chk("add_sr", sr1, 8'h05);
        cyc();
        chk("idle_res_vld", res_vld1, 1'b0);
        chk("idle_hold", wr_data1, 8'h10);

        run(4'h2, 8'h03, 8'h05, 2'd0);
        chk("sub_data", wr_data1, 8'hFE);
        chk("sub_sr", sr1, 8'h05);
        run(4'h7, 8'h10, 8'h01, 2'd0);
        chk("sbc_data", wr_data1, 8'h0E);
        chk("sbc_sr", sr1, 8'h04);
        run(4'h2, 8'h05, 8'h05, 2'd0);
        chk("subz_data", wr_data1, 8'h00);
        chk("subz_sr", sr1, 8'h08);

        // MUL accepted at edge N; ignored ADD offers during the busy window.
        run(4'hA, 8'h12, 8'h34, 2'd2);
        chk("nomul_res_vld", res_vld0, 1'b0);
        chk("nomul_sr", sr0, 8'h18);
        chk("nomul_in_rdy", in_rdy0, 1'b1);
        chk("mul_sr_hold", sr1, 8'h08);
        for (int k = 1; k <= 8; k++) begin
            if (k <= 3) begin
                in_vld = 1'b1; op = 4'h1; src0 = 8'h01; src1 = 8'h01; dst_sel = 2'd3;
            end else begin
                in_vld = 1'b0; op = 4'h0;
            end
            cyc();
            chk("mul_in_rdy", in_rdy1, 1'b0);
            chk("mul_busy", busy1, 1'b1);
            chk("mul_no_res", res_vld1, 1'b0);
        end
        in_vld = 1'b0; op = 4'h0;
        cyc();
        chk("mul_res_vld", res_vld1, 1'b1);
        chk("mul_wr_en", wr_en1, 1'b1);
        chk("mul_lo", wr_data1, 8'hA8);
        chk("mul_hi", wr_data_hi1, 8'h03);
        chk("mul_sel", wr_sel1, 2'd2);
        chk("mul_sr", sr1, 8'h05);
        chk("mul_done_rdy", in_rdy1, 1'b0);
        chk("mul_done_busy", busy1, 1'b0);
        cyc();
        chk("mul_back_rdy", in_rdy1, 1'b1);
        chk("mul_pulse", res_vld1, 1'b0);
        chk("mul_hold", wr_data1, 8'hA8);
        trap_clr = 1'b1; cyc(); trap_clr = 1'b0;

        run(4'h1, 8'h01, 8'h02, 2'd0);
        chk("pre_ill_sr", sr1, 8'h04);
        run(4'hF, 8'h11, 8'h22, 2'd1);
        chk("ill_res_vld", res_vld1, 1'b0);
        chk("ill_wr_en", wr_en1, 1'b0);
        chk("ill_sr", sr1, 8'h14);
        chk("ill_hold", wr_data1, 8'h03);
        run(4'h1, 8'h01, 8'h01, 2'd0);
        chk("trp_sticky", sr1, 8'h14);
        chk("trp_add_data", wr_data1, 8'h02);
        trap_clr = 1'b1; cyc(); trap_clr = 1'b0;
        chk("trp_clr", sr1, 8'h04);
        trap_clr = 1'b1;
        run(4'hF, 8'h00, 8'h00, 2'd0);
        trap_clr = 1'b0;
        chk("trp_clr_wins", sr1, 8'h04);

        run(4'hB, 8'h40, 8'h40, 2'd1);
        chk("cmp_res_vld", res_vld1, 1'b1);
        chk("cmp_wr_en", wr_en1, 1'b0);
        chk("cmp_sr", sr1, 8'h08);

        sr_wr = 1'b1; sr_wr_data = 8'hFF;
        run(4'h1, 8'h01, 8'h01, 2'd3);
        sr_wr = 1'b0;
        chk("srwr_sr", sr1, 8'h1F);
        chk("srwr_wr_en", wr_en1, 1'b1);
        chk("srwr_data", wr_data1, 8'h02);

        run(4'h6, 8'hFF, 8'h00, 2'd0);
        chk("adc1_data", wr_data1, 8'h00);
        chk("adc1_sr", sr1, 8'h19);
        run(4'h6, 8'h00, 8'h00, 2'd0);
        chk("adc2_data", wr_data1, 8'h01);
        chk("adc2_sr", sr1, 8'h14);
        trap_clr = 1'b1; cyc(); trap_clr = 1'b0;
        chk("clr2_sr", sr1, 8'h04);

        run(4'h8, 8'h81, 8'h00, 2'd0);
        chk("shl_data", wr_data1, 8'h02);
        chk("shl_sr", sr1, 8'h05);
        run(4'h9, 8'h01, 8'h00, 2'd0);
        chk("shr_data", wr_data1, 8'h00);
        chk("shr_sr", sr1, 8'h09);
        run(4'h3, 8'h0F, 8'h30, 2'd0);
        chk("or_data", wr_data1, 8'h3F);
        chk("or_sr", sr1, 8'h04);
        run(4'h4, 8'hF0, 8'h0F, 2'd0);
        chk("and_sr", sr1, 8'h08);
        run(4'h5, 8'hA5, 8'h5A, 2'd0);
        chk("xor_data", wr_data1, 8'hFF);
        run(4'h0, 8'h12, 8'h34, 2'd0);
        chk("nop_res_vld", res_vld1, 1'b0);
        chk("nop_sr", sr1, 8'h04);
        run(4'h1, 8'hFF, 8'h01, 2'd0);
        chk("addwrap_sr", sr1, 8'h09);
        run(4'h1, 8'h10, 8'h20, 2'd1);
        chk("pre_rst_data", wr_data1, 8'h30);

        // Reset four cycles into a multiply, asserted mid-cycle.
        run(4'hA, 8'hFF, 8'hFF, 2'd2);
        cyc(); cyc(); cyc();
        #2 reset_ = 1'b1;
        #1;
        chk("arst_sr", sr1, 8'h00);
        chk("arst_data", wr_data1, 8'h00);
        chk("arst_hi", wr_data_hi1, 8'h00);
        chk("arst_sel", wr_sel1, 2'd0);
        chk("arst_busy", busy1, 1'b0);
        chk("arst_res_vld", res_vld1, 1'b0);
        chk("arst_in_rdy", in_rdy1, 1'b0);
        cyc();
        reset_ = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("post_rst_res_vld", res_vld1, 1'b0);
            chk("post_rst_in_rdy", in_rdy1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
